// File: rtl/rotl4_share_arbiter.sv
// Round-robin arbiter that shares one 4-bit left-rotate datapath between two requesters.
// Results come back on a single valid/ready channel, tagged with the requester id.
module rotl4_share_arbiter #(
  parameter logic RR_START = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req0_valid,
  input  logic [3:0] req0_data,
  input  logic [1:0] req0_amt,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [3:0] req1_data,
  input  logic [1:0] req1_amt,
  output logic       req1_ready,
  output logic       res_valid,
  output logic [3:0] res_data,
  output logic       res_id,
  input  logic       res_ready,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROT  = 2'd1,
    RES  = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;

  logic       prio;
  logic [3:0] op_data;
  logic [1:0] op_amt;
  logic       op_id;

  logic       grant;
  logic       accept;
  logic [3:0] rot_stage1;
  logic [3:0] rot_out;

  // prio only matters when both requesters compete; a lone requester always wins
  always_comb begin
    grant = req1_valid;
    if (req0_valid && req1_valid) begin
      grant = prio;
    end
  end

  // ready is gated by reset_n so it reads 0 while the block is held in reset
  assign req0_ready = reset_n && (state == IDLE) && !grant && req0_valid;
  assign req1_ready = reset_n && (state == IDLE) &&  grant && req1_valid;
  assign accept     = req0_ready || req1_ready;
  assign busy       = (state != IDLE);

  // two-stage mux rotator: rotate by 1, then by 2
  always_comb begin
    rot_stage1 = op_amt[0] ? {op_data[2:0], op_data[3]}       : op_data;
    rot_out    = op_amt[1] ? {rot_stage1[1:0], rot_stage1[3:2]} : rot_stage1;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = ROT;
        end
      end
      ROT: begin
        state_next = RES;
      end
      RES: begin
        if (res_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // an operation in flight is discarded by reset; no result ever appears for it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prio      <= RR_START;
      op_data   <= 4'd0;
      op_amt    <= 2'd0;
      op_id     <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= 4'd0;
      res_id    <= 1'b0;
    end else begin
      if (accept) begin
        op_data <= grant ? req1_data : req0_data;
        op_amt  <= grant ? req1_amt  : req0_amt;
        op_id   <= grant;
      end
      if (state == ROT) begin
        res_data  <= rot_out;
        res_id    <= op_id;
        res_valid <= 1'b1;
      end
      if ((state == RES) && res_valid && res_ready) begin
        res_valid <= 1'b0;
        prio      <= ~res_id;
      end
    end
  end

endmodule

// File: tb/tb_rotl4_share_arbiter.sv
// Scoreboard bench for rotl4_share_arbiter: expected results are queued as requests are
// driven and matched against every result handshake.
module tb_rotl4_share_arbiter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req0_valid;
  logic [3:0] req0_data;
  logic [1:0] req0_amt;
  logic       req0_ready;
  logic       req1_valid;
  logic [3:0] req1_data;
  logic [1:0] req1_amt;
  logic       req1_ready;
  logic       res_valid;
  logic [3:0] res_data;
  logic       res_id;
  logic       res_ready;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;
  logic [4:0] sbq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  rotl4_share_arbiter #(.RR_START(1'b0)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_amt(req0_amt), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_amt(req1_amt), .req1_ready(req1_ready),
    .res_valid(res_valid), .res_data(res_data), .res_id(res_id), .res_ready(res_ready),
    .busy(busy)
  );

  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference rotate written from the index definition, not the mux structure
  function automatic logic [3:0] refRot(input logic [3:0] d, input logic [1:0] a);
    logic [3:0] r;
    logic [1:0] idx;
    for (int i = 0; i < 4; i++) begin
      idx  = 2'(i - int'(a));
      r[i] = d[idx];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // result monitor: every result handshake must match the head of the scoreboard
  always @(negedge clk) begin
    if (reset_n) begin
      checkOutput("ready_onehot", 8'(req0_ready & req1_ready), 8'd0);
      if (res_valid && res_ready) begin
        if (sbq.size() == 0) begin
          checkOutput("unexpected_result", 8'({res_id, res_data}), 8'hff);
        end else begin
          checkOutput("result", 8'({res_id, res_data}), 8'(sbq.pop_front()));
        end
      end
    end
  end

  task automatic applyStimulus(input logic id, input logic [3:0] d, input logic [1:0] a,
                               input bit pushExp, output int hsCycle);
    if (id) begin
      req1_valid = 1'b1; req1_data = d; req1_amt = a;
    end else begin
      req0_valid = 1'b1; req0_data = d; req0_amt = a;
    end
    if (pushExp) sbq.push_back({id, refRot(d, a)});
    hsCycle = -1;
    for (int k = 0; k < 30 && hsCycle < 0; k++) begin
      #1;
      if (id ? req1_ready : req0_ready) hsCycle = cycle;
      tick();
    end
    if (hsCycle < 0) checkOutput("accept_timeout", 8'd1, 8'd0);
    if (id) req1_valid = 1'b0;
    else    req0_valid = 1'b0;
  endtask

  task automatic applyPair(input logic [3:0] d0, input logic [1:0] a0,
                           input logic [3:0] d1, input logic [1:0] a1, input logic first);
    bit done0 = 0;
    bit done1 = 0;
    bit seen  = 0;
    logic r0, r1;
    sbq.push_back(first ? {1'b1, refRot(d1, a1)} : {1'b0, refRot(d0, a0)});
    sbq.push_back(first ? {1'b0, refRot(d0, a0)} : {1'b1, refRot(d1, a1)});
    req0_valid = 1'b1; req0_data = d0; req0_amt = a0;
    req1_valid = 1'b1; req1_data = d1; req1_amt = a1;
    for (int k = 0; k < 40 && !(done0 && done1); k++) begin
      #1;
      r0 = req0_ready;
      r1 = req1_ready;
      if (!seen && (r0 || r1)) begin
        checkOutput("first_grant", 8'({r1, r0}), first ? 8'd2 : 8'd1);
        seen = 1;
      end
      tick();
      if (r0) begin req0_valid = 1'b0; done0 = 1; end
      if (r1) begin req1_valid = 1'b0; done1 = 1; end
    end
    if (!(done0 && done1)) checkOutput("pair_timeout", 8'd1, 8'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while ((sbq.size() != 0 || busy) && k < 50) begin
      tick();
      k++;
    end
    checkOutput("drain_timeout", 8'(k >= 50), 8'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int hs, hsA, hsB;
    reset_n = 1'b0; res_ready = 1'b1;
    req0_valid = 1'b1; req0_data = 4'h5; req0_amt = 2'd1;
    req1_valid = 1'b0; req1_data = 4'h0; req1_amt = 2'd0;
    #2;
    checkOutput("rst_res_valid", 8'(res_valid), 8'd0);
    checkOutput("rst_res_data", 8'(res_data), 8'd0);
    checkOutput("rst_res_id", 8'(res_id), 8'd0);
    checkOutput("rst_busy", 8'(busy), 8'd0);
    checkOutput("rst_req0_ready", 8'(req0_ready), 8'd0);
    checkOutput("rst_req1_ready", 8'(req1_ready), 8'd0);
    req0_valid = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick();

    $display("[TB] single request on req0");
    req0_valid = 1'b1; req0_data = 4'b0001; req0_amt = 2'd1;
    sbq.push_back({1'b0, refRot(4'b0001, 2'd1)});
    #1 checkOutput("t1_req0_ready", 8'(req0_ready), 8'd1);
    tick();
    req0_valid = 1'b0;
    checkOutput("t1_busy", 8'(busy), 8'd1);
    checkOutput("t1_rot_no_valid", 8'(res_valid), 8'd0);
    tick();
    checkOutput("t1_res_valid", 8'(res_valid), 8'd1);
    checkOutput("t1_res_data", 8'(res_data), 8'b0010);
    checkOutput("t1_res_id", 8'(res_id), 8'd0);
    drain();

    $display("[TB] amount sweep on req1");
    for (int a = 0; a < 4; a++) applyStimulus(1'b1, 4'b1011, 2'(a), 1, hs);
    drain();

    $display("[TB] simultaneous requests from reset");
    reset_n = 1'b0; tick(); reset_n = 1'b1; tick();
    applyPair(4'b1000, 2'd1, 4'b0110, 2'd2, 1'b0);
    drain();
    applyPair(4'b1000, 2'd1, 4'b0110, 2'd2, 1'b0);
    drain();

    $display("[TB] backpressure with both requesters waiting");
    res_ready = 1'b0;
    req0_valid = 1'b1; req0_data = 4'b0011; req0_amt = 2'd1;
    req1_valid = 1'b1; req1_data = 4'b0101; req1_amt = 2'd3;
    sbq.push_back({1'b0, refRot(4'b0011, 2'd1)});
    #1 checkOutput("t4_grant0", 8'({req1_ready, req0_ready}), 8'd1);
    tick();
    req0_data = 4'b1111; req0_amt = 2'd2;
    tick();
    for (int k = 0; k < 5; k++) begin
      checkOutput("t4_hold_valid", 8'(res_valid), 8'd1);
      checkOutput("t4_hold_result", 8'({res_id, res_data}), 8'({1'b0, 4'b0110}));
      checkOutput("t4_hold_readys", 8'({req1_ready, req0_ready}), 8'd0);
      tick();
    end
    res_ready = 1'b1;
    sbq.push_back({1'b1, refRot(4'b0101, 2'd3)});
    tick();
    #1 checkOutput("t4_grant_other", 8'({req1_ready, req0_ready}), 8'd2);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    drain();

    $display("[TB] req1 back-to-back");
    applyStimulus(1'b1, 4'b1001, 2'd1, 1, hsA);
    applyStimulus(1'b1, 4'b0111, 2'd3, 1, hsB);
    checkOutput("t5_gap", 8'(hsB - hsA), 8'd3);
    drain();

    $display("[TB] reset while rotating");
    applyStimulus(1'b0, 4'b0100, 2'd2, 1, hs);
    drain();
    req0_valid = 1'b1; req0_data = 4'b1100; req0_amt = 2'd1;
    #1 checkOutput("t6_accept", 8'(req0_ready), 8'd1);
    tick();
    req0_valid = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    checkOutput("t6_busy", 8'(busy), 8'd0);
    checkOutput("t6_res_valid", 8'(res_valid), 8'd0);
    checkOutput("t6_res_data", 8'(res_data), 8'd0);
    tick(); tick();
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput("t6_no_stale", 8'({busy, res_valid}), 8'd0);
    end
    applyPair(4'b0010, 2'd3, 4'b1110, 2'd1, 1'b0);
    drain();

    checkOutput("sb_empty", 8'(sbq.size()), 8'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
